// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide engine.
// The FUNC_* request codes mirror the ALU's mulalu_func encoding.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_t;

    localparam int DATA_W_DEF = 32;
    localparam int ITERS      = DATA_W_DEF;

    localparam logic [DATA_W_DEF-1:0] DIV0_QUOT = '1;

    localparam logic [4:0] FUNC_NONE = 5'b00000;
    localparam logic [4:0] FUNC_MUL  = 5'b11000;
    localparam logic [4:0] FUNC_DIV  = 5'b11010;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation for the multiply/divide engine.
// Used on the way in to take operand magnitudes and on the way out to
// restore result signs. With 'joint' set, the two halves are negated as one
// double-width value under 'neg_lo'; otherwise each half negates on its own.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_hi,
    input  logic [W-1:0] in_lo,
    input  logic         neg_hi,
    input  logic         neg_lo,
    input  logic         joint,
    output logic [W-1:0] out_hi,
    output logic [W-1:0] out_lo
);

    logic [2*W-1:0] wide_neg;

    assign wide_neg = -{in_hi, in_lo};

    // Select pass-through, per-half negate or full double-width negate
    always_comb begin
        out_hi = in_hi;
        out_lo = in_lo;
        if (joint) begin
            if (neg_lo) begin
                {out_hi, out_lo} = wide_neg;
            end
        end else begin
            if (neg_hi) begin
                out_hi = -in_hi;
            end
            if (neg_lo) begin
                out_lo = -in_lo;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine for the EX stage.
// Iterative shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle, followed by a sign-fix cycle and a one-cycle HI/LO
// write strobe. Define MULDIV_FAST_MUL_EN to compute MUL in a single CALC
// cycle with a native multiplier; DIV is always iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [4:0]        mulalu_func,
    input  logic              mulalu_sign,
    input  logic [DATA_W-1:0] source_a,
    input  logic [DATA_W-1:0] source_b,
    output logic              busy,
    output logic              hi_write,
    output logic [DATA_W-1:0] hi_write_data,
    output logic              lo_write,
    output logic [DATA_W-1:0] lo_write_data
);

    state_t state, next_state;
    op_t    op;

    logic              res_sign, rem_sign, div0;
    logic [DATA_W-1:0] acc_hi, acc_lo, opnd;
    logic [5:0]        count;
    logic              accept, calc_last, is_req;
    logic              sign_a, sign_b;
    logic [DATA_W-1:0] abs_a, abs_b, fix_hi, fix_lo;
    logic [DATA_W:0]   mul_sum, div_shift, div_trial;

    assign is_req = (mulalu_func == FUNC_MUL) || (mulalu_func == FUNC_DIV);
    assign accept = ((state == IDLE) || (state == DONE)) && !flush && is_req;
    assign busy   = (state == CALC) || (state == FIX);

    assign sign_a = mulalu_sign & source_a[DATA_W-1];
    assign sign_b = mulalu_sign & source_b[DATA_W-1];

`ifdef MULDIV_FAST_MUL_EN
    assign calc_last = (op == OP_MUL) || (count == 6'(DATA_W - 1));
`else
    assign calc_last = (count == 6'(DATA_W - 1));
`endif

    // One multiply step adds the multiplicand when the multiplier LSB is set;
    // one divide step shifts a dividend bit into the remainder and trials it.
    assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
    assign div_trial = div_shift - {1'b0, opnd};

    muldiv_signfix #(.W(DATA_W)) u_signfix_in (
        .in_hi  (source_a),
        .in_lo  (source_b),
        .neg_hi (sign_a),
        .neg_lo (sign_b),
        .joint  (1'b0),
        .out_hi (abs_a),
        .out_lo (abs_b)
    );

    muldiv_signfix #(.W(DATA_W)) u_signfix_out (
        .in_hi  (acc_hi),
        .in_lo  (acc_lo),
        .neg_hi (rem_sign),
        .neg_lo (res_sign),
        .joint  (op == OP_MUL),
        .out_hi (fix_hi),
        .out_lo (fix_lo)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush cancels everything and drops same-cycle requests
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) next_state = CALC;
                CALC:    if (calc_last) next_state = FIX;
                FIX:     next_state = DONE;
                DONE:    next_state = accept ? CALC : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Operand capture at accept and the per-cycle arithmetic during CALC.
    // Multiply keeps the product in acc_hi:acc_lo with the multiplier shifting
    // out of acc_lo; divide keeps the remainder in acc_hi and the quotient
    // shifting into acc_lo as dividend bits shift out.
    always_ff @(posedge clk) begin
        if (rst) begin
            op       <= OP_MUL;
            res_sign <= 1'b0;
            rem_sign <= 1'b0;
            div0     <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            count    <= '0;
        end else if (accept) begin
            count    <= '0;
            acc_hi   <= '0;
            res_sign <= sign_a ^ sign_b;
            rem_sign <= sign_a;
            div0     <= (source_b == '0);
            if (mulalu_func == FUNC_MUL) begin
                op     <= OP_MUL;
                opnd   <= abs_a;
                acc_lo <= abs_b;
            end else begin
                op     <= OP_DIV;
                opnd   <= abs_b;
                acc_lo <= abs_a;
            end
        end else if (state == CALC) begin
            count <= count + 6'd1;
            if (op == OP_MUL) begin
`ifdef MULDIV_FAST_MUL_EN
                {acc_hi, acc_lo} <= {{DATA_W{1'b0}}, opnd} * {{DATA_W{1'b0}}, acc_lo};
`else
                {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
`endif
            end else if (!div_trial[DATA_W]) begin
                acc_hi <= div_trial[DATA_W-1:0];
                acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
            end else begin
                acc_hi <= div_shift[DATA_W-1:0];
                acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Registered write strobes and data; data is captured leaving FIX and
    // held afterwards. Divide by zero forces the all-ones quotient while the
    // remainder path already reproduces the original dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_write      <= 1'b0;
            lo_write      <= 1'b0;
            hi_write_data <= '0;
            lo_write_data <= '0;
        end else begin
            hi_write <= (state == FIX) && !flush;
            lo_write <= (state == FIX) && !flush;
            if ((state == FIX) && !flush) begin
                hi_write_data <= fix_hi;
                lo_write_data <= ((op == OP_DIV) && div0) ? DIV0_QUOT : fix_lo;
            end
        end
    end

endmodule
